// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared FSM state type and length-field width helper for the sequence generator
package seq_gen_pkg;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    function automatic int lw_of(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sequence_generator_if.sv
// sequence_generator_if: start handshake, frame control and serial output bundle
interface sequence_generator_if #(
    parameter int WIDTH = 8,
    parameter int LW    = seq_gen_pkg::lw_of(WIDTH)
);
    logic             i_clear;
    logic             i_start_valid;
    logic             o_start_ready;
    logic [WIDTH-1:0] i_pattern;
    logic [LW-1:0]    i_length;
    logic             i_repeat;
    logic             i_stop;
    logic             o_d;
    logic             o_d_valid;
    logic             o_d_last;
    modport master (
        output i_clear, i_start_valid, i_pattern, i_length, i_repeat, i_stop,
        input  o_start_ready, o_d, o_d_valid, o_d_last
    );
    modport slave (
        input  i_clear, i_start_valid, i_pattern, i_length, i_repeat, i_stop,
        output o_start_ready, o_d, o_d_valid, o_d_last
    );
endinterface

// File: rtl/sequence_generator_piso.sv
// piso_shift_reg: parallel-load, shift-right register presenting bit 0 as the serial output
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);
    logic [WIDTH-1:0] r_sr;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_sr <= '0;
        else if (i_load) r_sr <= i_data;
        else if (i_shift) r_sr <= r_sr >> 1;
    end
    assign o_bit = r_sr[0];
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serialises a captured pattern LSB first, optionally looping until stopped
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = lw_of(WIDTH)
) (
    input logic                 i_clock,
    input logic                 i_reset,
    sequence_generator_if.slave bus
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_pat;
    logic [LW-1:0]    r_len, r_cnt, w_len;
    logic             r_rep, r_stop;
    logic             w_accept, w_end, w_reload, w_load, w_bit;

    assign w_len    = (bus.i_length > LW'(WIDTH)) ? LW'(WIDTH) : bus.i_length;
    assign w_accept = bus.i_start_valid && (r_state == IDLE) && !bus.i_clear;
    assign w_end    = (r_state == SEND) && (r_cnt == r_len - LW'(1));
    // a stop seen on the final bit itself still prevents the reload
    assign w_reload = w_end && r_rep && !r_stop && !bus.i_stop && !bus.i_clear;
    assign w_load   = (w_accept && (w_len != '0)) || w_reload;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = bus.i_clear ? IDLE :
                 (r_state == IDLE) ? ((w_accept && (w_len != '0)) ? SEND : IDLE) :
                 ((w_end && !w_reload) ? IDLE : SEND);
    end

    always_comb begin
        bus.o_start_ready = (r_state == IDLE);
        bus.o_d_valid     = (r_state == SEND);
        bus.o_d           = (r_state == SEND) && w_bit;
        bus.o_d_last      = w_end;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pat  <= '0;
            r_len  <= '0;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
            r_stop <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pat <= bus.i_pattern;
                r_len <= w_len;
                r_rep <= bus.i_repeat;
            end
            r_cnt  <= (bus.i_clear || w_load) ? '0 : (r_state == SEND) ? r_cnt + LW'(1) : r_cnt;
            r_stop <= (w_next == SEND) && (r_stop || ((r_state == SEND) && bus.i_stop));
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_shift ((r_state == SEND) && !w_load),
        .i_data  (w_accept ? bus.i_pattern : r_pat),
        .o_bit   (w_bit)
    );
endmodule
